patient_button_tx: RTL and testbench
====================================

// Module: patient_button_tx
// PURPOSE
//  Device-side transmitter for the patient button / pedal scan link. Lives in the button or pedal CPLD at the far end of the cable.
//  - Watches the host scan line; after each valid host scan pulse, answers with one 5-bit frame.
//  - Frame content: presence bit, device type, and 3 debounced key states.
//  - Runs on 1 MHz clk; the line is open-drain (this block only pulls low or releases).
// PARAMETERS
//  IS_BUTTON   1     1: button (type bit 1, keys[1:0] used, state bit2 forced 1); 0: pedal (type bit 0, keys[2:0])
//  SCAN_MIN    2     min accepted scan low width, cycles (shorter = glitch, ignored)
//  SCAN_MAX    12    max accepted scan low width, cycles (longer = line fault, ignored)
//  START_DLY   4     cycles from scan release (sync'd) to first bit marker
//  MARK_LEN    2     bit marker (forced low) length, cycles
//  DATA_LEN    5     data level hold length, cycles
//  REC_LEN     3     recovery (released) length, cycles; slot = MARK+DATA+REC = 10
//  DEB_CYCLES  5000  key debounce stability time, cycles (5 ms)
// PORTS
//  clk         in   1  1 MHz clock
//  rst         in   1  synchronous reset, active-high
//  scanIn      in   1  line level as read from the pad (async, low = pulled)
//  keysN       in   3  raw key contacts, active-low (0 = pressed), async
//  lineDrvLow  out  1  1 = pull line low, 0 = release (pad is open-drain)
//  busy        out  1  1 while a frame is in progress (GAP..REC)
//  frameDone   out  1  one-cycle strobe after last bit's recovery ends
//  keyState    out  3  debounced key states, 1 = released, 0 = pressed
// BEHAVIOUR
//  Reset (on clk edge with rst=1): lineDrvLow=0, busy=0, frameDone=0, keyState=3'b111, FSM=IDLE, all counters 0, sync FFs=1.
//  rst mid-frame: line is released on the same edge; no partial frame resumes.
//  Input sync: scanIn and keysN each pass through 2 FFs; all decisions use synced values.
//  Debounce: per key, a counter reloads on each change of the synced input. After DEB_CYCLES stable cycles, keyState[i] <= synced input.
//  Snapshot: frame word latched on entry to GAP as {1'b0, TYPE, st[2:0]}, sent MSB first.
//    TYPE = IS_BUTTON; st = IS_BUTTON ? {1'b1, keyState[1:0]} : keyState[2:0].
//    Key changes during a frame go into the next frame only.
//  FSM:
//    IDLE  -> SCAN  when synced scan=0; width counter starts at 1.
//    SCAN: width counter counts up while scan=0 and saturates at SCAN_MAX+1.
//      On scan=1: width in [SCAN_MIN, SCAN_MAX] -> GAP; otherwise -> IDLE.
//    GAP: START_DLY cycles, line released -> MARK (bit index 4).
//    MARK: lineDrvLow=1 for MARK_LEN cycles -> DATA.
//    DATA: lineDrvLow = ~word[idx] for DATA_LEN cycles -> REC.
//    REC: lineDrvLow=0 for REC_LEN cycles.
//      idx>0 -> idx-1, MARK. idx==0 -> IDLE with frameDone=1 for 1 cycle.
//  Frame timing: scan release to frame end = 2 (sync) + START_DLY + 5*10 = 56 cycles. Host read window is 70 cycles.
//  Bit slot n (n=0 for bit4) starts 2+START_DLY+10n cycles after scan release. The host samples ~5 cycles after the marker edge, inside DATA.
//  The REC high time guarantees a falling edge at every marker, including after a 0 bit.
//  scanIn is ignored in GAP..REC, because our own drive appears on the wire. Scan counting restarts only from IDLE.
//  If a scan pulse arrives while busy, it is dropped. No queueing.
//  busy = FSM in {GAP, MARK, DATA, REC}.
//  Counters are sized to hold max(param)+1 with no wrap. Bit index is 3 bits and is decremented only in REC.
// CONFIGURATION
//  PB_SCAN_TYPE_MATCH_EN defined: answer only scans that match the device type.
//    Button: width >= 6. Pedal: width <= 5.
//    Host alternates 8 us / 3 us scans, so the device answers every 2nd scan.
//    A non-matching scan of valid width goes SCAN -> IDLE.
//  Not defined: answer every scan with width in [SCAN_MIN, SCAN_MAX].
// TESTING
//  1. IS_BUTTON=1, keysN=3'b111 stable, scan low 8 cycles.
//     Response: word 5'b01111; 5 markers at 10-cycle pitch; data phases 1,1,1,1 after bit4=0; frameDone 56 cycles after release.
//  2. Hold keysN[0]=0 for 6000 cycles, then scan.
//     Response: keyState=3'b110, word 5'b01110. A 3000-cycle glitch leaves keyState=3'b111.
//  3. IS_BUTTON=0, keysN=3'b010 debounced, scan 3 cycles.
//     Response: word 5'b00010. Line model (pull-up) sampled by a host model 5 cycles after each fall decodes 00010.
//  4. Scan of 1 cycle, and scan of 20 cycles.
//     Response: no lineDrvLow, busy=0, no frameDone.
//  5. Second scan pulse during bit 2, and rst asserted during bit 2.
//     Response: first case, frame completes unchanged. Second case, lineDrvLow=0 and busy=0 on the next edge, and keyState=3'b111.
//  6. PB_SCAN_TYPE_MATCH_EN, IS_BUTTON=1, alternating 8/3-cycle scans 1000 cycles apart.
//     Response: frames only after the 8-cycle scans. Without the macro: a frame after every scan.

Source files
------------

// File: rtl/patient_button_tx.sv
// patient_button_tx: device-side transmitter for the patient button / pedal scan link.
// Optional feature: define PB_SCAN_TYPE_MATCH_EN to answer only scans matching the device type.
module patient_button_tx #(
    parameter int IS_BUTTON  = 1,
    parameter int SCAN_MIN   = 2,
    parameter int SCAN_MAX   = 12,
    parameter int START_DLY  = 4,
    parameter int MARK_LEN   = 2,
    parameter int DATA_LEN   = 5,
    parameter int REC_LEN    = 3,
    parameter int DEB_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scanIn,
    input  logic [2:0] keysN,
    output logic       lineDrvLow,
    output logic       busy,
    output logic       frameDone,
    output logic [2:0] keyState
);

    localparam int PH_A   = (START_DLY > MARK_LEN) ? START_DLY : MARK_LEN;
    localparam int PH_B   = (DATA_LEN > REC_LEN) ? DATA_LEN : REC_LEN;
    localparam int PH_MAX = (PH_A > PH_B) ? PH_A : PH_B;
    localparam int PW     = $clog2(PH_MAX + 2);
    localparam int WW     = $clog2(SCAN_MAX + 2);
    localparam int DW     = $clog2(DEB_CYCLES + 2);

    localparam logic TYPE_BIT = (IS_BUTTON != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_GAP,
        S_MARK,
        S_DATA,
        S_REC
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [4:0]      word_q, word_d;
    logic            line_drv_low_q, line_drv_low_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;

    logic            scan_s1_q, scan_s1_d;
    logic            scan_s2_q, scan_s2_d;

    logic [2:0]      keys_s1_q, keys_s1_d;
    logic [2:0]      keys_s2_q, keys_s2_d;
    logic [2:0]      keys_prev_q, keys_prev_d;
    logic [2:0]      key_state_q, key_state_d;
    logic [DW-1:0]   deb_cnt_q [3];
    logic [DW-1:0]   deb_cnt_d [3];

    logic            width_ok;
    logic            type_ok;
    logic [2:0]      snap_st;
    logic [4:0]      snap_word;

    assign width_ok = (wcnt_q >= WW'(SCAN_MIN)) && (wcnt_q <= WW'(SCAN_MAX));

`ifdef PB_SCAN_TYPE_MATCH_EN
    // Host alternates long (button) and short (pedal) scans.
    assign type_ok = (IS_BUTTON != 0) ? (wcnt_q >= WW'(6)) : (wcnt_q <= WW'(5));
`else
    assign type_ok = 1'b1;
`endif

    assign snap_st   = (IS_BUTTON != 0) ? {1'b1, key_state_q[1:0]} : key_state_q;
    assign snap_word = {1'b0, TYPE_BIT, snap_st};

    // Two-FF synchronisers for the scan line and the key contacts.
    always_comb begin
        scan_s1_d   = scanIn;
        scan_s2_d   = scan_s1_q;
        keys_s1_d   = keysN;
        keys_s2_d   = keys_s1_q;
        keys_prev_d = keys_s2_q;
    end

    // Per-key debounce: counter restarts on any change, state follows once stable.
    always_comb begin
        key_state_d = key_state_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            if (keys_s2_q[i] != keys_prev_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] != DW'(DEB_CYCLES)) begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end else begin
                key_state_d[i] = keys_s2_q[i];
            end
        end
    end

    // Frame FSM: scan width qualification, then five marker/data/recovery slots.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        pcnt_d       = pcnt_q;
        idx_d        = idx_q;
        word_d       = word_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!scan_s2_q) begin
                    state_d = S_SCAN;
                    wcnt_d  = WW'(1);
                end
            end
            S_SCAN: begin
                if (!scan_s2_q) begin
                    if (wcnt_q != WW'(SCAN_MAX + 1)) begin
                        wcnt_d = wcnt_q + WW'(1);
                    end
                end else if (width_ok && type_ok) begin
                    state_d = S_GAP;
                    pcnt_d  = '0;
                    word_d  = snap_word;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (pcnt_q == PW'(START_DLY - 1)) begin
                    state_d = S_MARK;
                    pcnt_d  = '0;
                    idx_d   = 3'd4;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            S_MARK: begin
                if (pcnt_q == PW'(MARK_LEN - 1)) begin
                    state_d = S_DATA;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            S_DATA: begin
                if (pcnt_q == PW'(DATA_LEN - 1)) begin
                    state_d = S_REC;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            S_REC: begin
                if (pcnt_q == PW'(REC_LEN - 1)) begin
                    pcnt_d = '0;
                    if (idx_q == 3'd0) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = S_MARK;
                        idx_d   = idx_q - 3'd1;
                    end
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered pad drive and busy, derived from the next state.
    always_comb begin
        line_drv_low_d = 1'b0;
        busy_d         = 1'b0;
        unique case (state_d)
            S_GAP: begin
                busy_d = 1'b1;
            end
            S_MARK: begin
                busy_d         = 1'b1;
                line_drv_low_d = 1'b1;
            end
            S_DATA: begin
                busy_d         = 1'b1;
                line_drv_low_d = ~word_d[idx_d];
            end
            S_REC: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset releases the line at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wcnt_q         <= '0;
            pcnt_q         <= '0;
            idx_q          <= '0;
            word_q         <= '0;
            line_drv_low_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            scan_s1_q      <= 1'b1;
            scan_s2_q      <= 1'b1;
            keys_s1_q      <= 3'b111;
            keys_s2_q      <= 3'b111;
            keys_prev_q    <= 3'b111;
            key_state_q    <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            pcnt_q         <= pcnt_d;
            idx_q          <= idx_d;
            word_q         <= word_d;
            line_drv_low_q <= line_drv_low_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            scan_s1_q      <= scan_s1_d;
            scan_s2_q      <= scan_s2_d;
            keys_s1_q      <= keys_s1_d;
            keys_s2_q      <= keys_s2_d;
            keys_prev_q    <= keys_prev_d;
            key_state_q    <= key_state_d;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign lineDrvLow = line_drv_low_q;
    assign busy       = busy_q;
    assign frameDone  = frame_done_q;
    assign keyState   = key_state_q;

endmodule

// File: tb/tb_patient_button_tx.sv
// tb_patient_button_tx: button and pedal instances driven by a host/line model.
// Expected frames come from the link rules (width window, word layout, slot pitch).
`timescale 1ns/1ps
module tb_patient_button_tx;

    localparam int DEB_B = 5000;
    localparam int DEB_P = 200;

    logic       clk;
    logic [1:0] rst;
    logic [1:0] scan;
    logic [2:0] keys_b, keys_p;
    logic [1:0] drv, bsy, dn;
    logic [2:0] kst_b, kst_p;

    int checks = 0;
    int errors = 0;

    logic [2:0] deb_b, deb_p;

    typedef struct {
        int         s;
        int         w;
        logic [2:0] k;
        int         inj;
        bit         ef;
        logic [4:0] ew;
    } vec_t;

    vec_t tbl [11];

    patient_button_tx #(
        .IS_BUTTON(1),
        .DEB_CYCLES(DEB_B)
    ) u_btn (
        .clk(clk),
        .rst(rst[0]),
        .scanIn(scan[0]),
        .keysN(keys_b),
        .lineDrvLow(drv[0]),
        .busy(bsy[0]),
        .frameDone(dn[0]),
        .keyState(kst_b)
    );

    patient_button_tx #(
        .IS_BUTTON(0),
        .DEB_CYCLES(DEB_P)
    ) u_ped (
        .clk(clk),
        .rst(rst[1]),
        .scanIn(scan[1]),
        .keysN(keys_p),
        .lineDrvLow(drv[1]),
        .busy(bsy[1]),
        .frameDone(dn[1]),
        .keyState(kst_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic bit accept(input int s, input int w);
        bit ok;
        ok = (w >= 2) && (w <= 12);
`ifdef PB_SCAN_TYPE_MATCH_EN
        if (s == 0) ok = ok && (w >= 6);
        else ok = ok && (w <= 5);
`endif
        return ok;
    endfunction

    function automatic logic [4:0] exp_word(input int s, input logic [2:0] k);
        if (s == 0) return {1'b0, 1'b1, 1'b1, k[1:0]};
        return {1'b0, 1'b0, k};
    endfunction

    function automatic vec_t mk(input int s, input int w, input logic [2:0] k, input int inj);
        vec_t v;
        v.s   = s;
        v.w   = w;
        v.k   = k;
        v.inj = inj;
        v.ef  = accept(s, w);
        v.ew  = exp_word(s, k);
        return v;
    endfunction

    function automatic int kst_of(input int s);
        return (s == 0) ? int'(kst_b) : int'(kst_p);
    endfunction

    task automatic set_keys(input int s, input logic [2:0] v);
        if (s == 0) keys_b = v;
        else keys_p = v;
    endtask

    // Host model: scan low w cycles, then decode the pulled-up line for 80 cycles.
    task automatic scan_frame(input int s, input int w, input int inj,
                              input bit ef, input logic [4:0] ew, input string nm);
        int marks, dones, done_j, lows, busys, samp;
        bit prev, line, pitch_ok;
        logic [4:0] word;
        marks = 0; dones = 0; done_j = -1; lows = 0; busys = 0; samp = -1;
        prev = 1'b1; pitch_ok = 1'b1; word = '0;
        @(negedge clk);
        scan[s] = 1'b0;
        repeat (w) @(negedge clk);
        scan[s] = 1'b1;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            line = ~drv[s];
            if (drv[s]) lows++;
            if (bsy[s]) busys++;
            if (prev && !line) begin
                if (j != 6 + 10 * marks) pitch_ok = 1'b0;
                marks++;
                samp = j + 5;
            end
            if (j == samp) word = {word[3:0], line};
            if (dn[s]) begin
                dones++;
                done_j = j;
            end
            prev = line;
            if (j == inj) scan[s] = 1'b0;
            if (j == inj + 8) scan[s] = 1'b1;
        end
        if (ef) begin
            chk({nm, " markers"}, marks, 5);
            chk({nm, " pitch"}, int'(pitch_ok), 1);
            chk({nm, " word"}, int'(word), int'(ew));
            chk({nm, " low_cycles"}, lows, 10 + 5 * (5 - $countones(ew)));
            chk({nm, " done_at"}, done_j, 56);
            chk({nm, " done_cnt"}, dones, 1);
            chk({nm, " busy_cycles"}, busys, 54);
        end else begin
            chk({nm, " no_drive"}, lows, 0);
            chk({nm, " no_busy"}, busys, 0);
            chk({nm, " no_done"}, dones, 0);
        end
    endtask

    initial begin
        logic [2:0] nk;
        int         wr, lows, dones;

        rst = 2'b11;
        scan = 2'b11;
        keys_b = 3'b111;
        keys_p = 3'b111;
        deb_b = 3'b111;
        deb_p = 3'b111;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset drv%0d", s), int'(drv[s]), 0);
            chk($sformatf("reset busy%0d", s), int'(bsy[s]), 0);
            chk($sformatf("reset done%0d", s), int'(dn[s]), 0);
            chk($sformatf("reset kst%0d", s), kst_of(s), 7);
        end
        rst = 2'b00;
        repeat (5) @(negedge clk);

        // 3000-cycle glitch on key 0 must not reach keyState.
        keys_b = 3'b110;
        repeat (3000) @(negedge clk);
        chk("glitch during", int'(kst_b), 7);
        keys_b = 3'b111;
        repeat (100) @(negedge clk);
        chk("glitch after", int'(kst_b), 7);

        tbl[0]  = mk(0, 8, 3'b111, -1);
        tbl[1]  = mk(0, 1, 3'b111, -1);
        tbl[2]  = mk(0, 20, 3'b111, -1);
        tbl[3]  = mk(0, 2, 3'b111, -1);
        tbl[4]  = mk(0, 12, 3'b111, -1);
        tbl[5]  = mk(0, 13, 3'b111, -1);
        tbl[6]  = mk(0, 6, 3'b110, -1);
        tbl[7]  = mk(0, 8, 3'b110, 30);
        tbl[8]  = mk(1, 3, 3'b010, -1);
        tbl[9]  = mk(1, 5, 3'b010, -1);
        tbl[10] = mk(1, 8, 3'b101, -1);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].k != ((tbl[i].s == 0) ? deb_b : deb_p)) begin
                set_keys(tbl[i].s, tbl[i].k);
                repeat (((tbl[i].s == 0) ? DEB_B : DEB_P) + 50) @(negedge clk);
                chk($sformatf("vec%0d keystate", i), kst_of(tbl[i].s), int'(tbl[i].k));
                if (tbl[i].s == 0) deb_b = tbl[i].k;
                else deb_p = tbl[i].k;
            end
            scan_frame(tbl[i].s, tbl[i].w, tbl[i].inj, tbl[i].ef, tbl[i].ew,
                       $sformatf("vec%0d", i));
            repeat (20) @(negedge clk);
        end

        // Host alternates 8/3-cycle scans 1000 cycles apart.
        for (int i = 0; i < 4; i++) begin
            wr = (i % 2 == 0) ? 8 : 3;
            scan_frame(0, wr, -1, accept(0, wr), exp_word(0, deb_b),
                       $sformatf("alt%0d", i));
            repeat (900) @(negedge clk);
        end

        // Randomised key activity and scan widths on the pedal.
        for (int it = 0; it < 12; it++) begin
            nk = 3'($urandom_range(0, 7));
            wr = $urandom_range(1, 20);
            keys_p = nk;
            if ($urandom_range(0, 1) == 1) begin
                repeat (DEB_P + $urandom_range(20, 80)) @(negedge clk);
                deb_p = nk;
            end else begin
                repeat ($urandom_range(1, DEB_P - 20)) @(negedge clk);
                keys_p = deb_p;
                repeat (5) @(negedge clk);
            end
            chk($sformatf("rnd%0d keystate", it), int'(kst_p), int'(deb_p));
            scan_frame(1, wr, -1, accept(1, wr), exp_word(1, deb_p),
                       $sformatf("rnd%0d w%0d", it, wr));
            repeat (10) @(negedge clk);
        end

        // Reset asserted during bit 2 of a button frame.
        @(negedge clk);
        scan[0] = 1'b0;
        repeat (8) @(negedge clk);
        scan[0] = 1'b1;
        repeat (31) @(negedge clk);
        chk("rst mid busy_before", int'(bsy[0]), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("rst mid drv", int'(drv[0]), 0);
        chk("rst mid busy", int'(bsy[0]), 0);
        chk("rst mid kst", int'(kst_b), 7);
        rst[0] = 1'b0;
        lows = 0;
        dones = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (drv[0]) lows++;
            if (dn[0]) dones++;
        end
        chk("rst no_resume drv", lows, 0);
        chk("rst no_resume done", dones, 0);
        scan_frame(0, 8, -1, accept(0, 8), exp_word(0, 3'b111), "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
